// File: rtl/seq_mult.sv
// Sequential shift-add multiplier: WIDTH-cycle iteration between valid/ready handshakes.
// Optional two's-complement operands when SEQ_MULT_SIGNED_EN is defined.
module seq_mult #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t               state_r;
  state_t               state_s;
  logic [WIDTH-1:0]     mcand_r;
  logic [WIDTH-1:0]     mplier_r;
  logic [2*WIDTH-1:0]   acc_r;
  logic [2*WIDTH-1:0]   acc_s;
  logic [2*WIDTH-1:0]   addend_s;
  logic [2*WIDTH-1:0]   result_s;
  logic [2*WIDTH-1:0]   p_r;
  logic [CNT_W-1:0]     cnt_r;
  logic                 in_ready_r;
  logic                 out_valid_r;
  logic                 busy_r;
  logic                 accept_s;
  logic                 last_s;
  logic [WIDTH-1:0]     a_cap_s;
  logic [WIDTH-1:0]     b_cap_s;

`ifdef SEQ_MULT_SIGNED_EN
  logic                 sign_r;

  // Two's-complement magnitude; the most negative value maps to 2^(WIDTH-1) unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] m;
    if (v[WIDTH-1]) begin
      m = (~v) + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      m = v;
    end
    return m;
  endfunction

  // Operand magnitudes captured at acceptance.
  always_comb begin
    a_cap_s = magnitude(a);
    b_cap_s = magnitude(b);
  end

  // Final product with sign restored.
  always_comb begin
    if (sign_r) begin
      result_s = (~acc_s) + {{(2*WIDTH-1){1'b0}}, 1'b1};
    end else begin
      result_s = acc_s;
    end
  end

  // Result sign register, loaded with the operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_r <= 1'b0;
    end else if (accept_s) begin
      sign_r <= a[WIDTH-1] ^ b[WIDTH-1];
    end else begin
      sign_r <= sign_r;
    end
  end
`else
  // Unsigned operands are captured as presented.
  always_comb begin
    a_cap_s  = a;
    b_cap_s  = b;
    result_s = acc_s;
  end
`endif

  // Partial product for the current iteration and the updated accumulator.
  always_comb begin
    if (mplier_r[0]) begin
      addend_s = {{WIDTH{1'b0}}, mcand_r} << cnt_r;
    end else begin
      addend_s = {(2*WIDTH){1'b0}};
    end
    acc_s = acc_r + addend_s;
  end

  // Next-state logic; accept only while in_ready is already asserted.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    last_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid && in_ready_r) begin
          accept_s = 1'b1;
          state_s  = RUN;
        end else begin
          state_s  = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == CNT_LAST) begin
          last_s  = 1'b1;
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Handshake and status flags are registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      in_ready_r  <= (state_s == IDLE);
      out_valid_r <= (state_s == DONE);
      busy_r      <= (state_s == RUN);
    end
  end

  // Shift-add datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_r  <= {WIDTH{1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      acc_r    <= {(2*WIDTH){1'b0}};
      cnt_r    <= CNT_ZERO;
    end else if (accept_s) begin
      mcand_r  <= a_cap_s;
      mplier_r <= b_cap_s;
      acc_r    <= {(2*WIDTH){1'b0}};
      cnt_r    <= CNT_ZERO;
    end else if (state_r == RUN) begin
      mcand_r  <= mcand_r;
      mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
      acc_r    <= acc_s;
      cnt_r    <= cnt_r + CNT_ONE;
    end else begin
      mcand_r  <= mcand_r;
      mplier_r <= mplier_r;
      acc_r    <= acc_r;
      cnt_r    <= cnt_r;
    end
  end

  // Product register: loaded on the final step, held through backpressure and after handoff.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_r <= {(2*WIDTH){1'b0}};
    end else if (last_s) begin
      p_r <= result_s;
    end else begin
      p_r <= p_r;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign p         = p_r;

endmodule

// File: tb/tb_seq_mult.sv
// Directed bench for seq_mult: WIDTH=4 vectors, backpressure, mid-run reset, WIDTH=8 back-to-back regression.
module tb_seq_mult;

  logic clk;
  logic rst_n;

  logic       in_valid4, in_ready4, out_valid4, out_ready4, busy4;
  logic [3:0] a4, b4;
  logic [7:0] p4;

  logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  int compared;
  int mismatched;

  seq_mult #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .out_valid(out_valid4), .out_ready(out_ready4),
    .p(p4), .busy(busy4)
  );

  seq_mult #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8),
    .p(p8), .busy(busy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  function automatic logic [15:0] model8(input logic [7:0] x, input logic [7:0] y);
`ifdef SEQ_MULT_SIGNED_EN
    logic signed [15:0] xs, ys;
    xs = $signed({{8{x[7]}}, x});
    ys = $signed({{8{y[7]}}, y});
    return 16'(xs * ys);
`else
    return {8'h00, x} * {8'h00, y};
`endif
  endfunction

  task automatic wait_ready4(input string tag);
    for (int i = 0; i < 50 && in_ready4 !== 1'b1; i++) @(negedge clk);
    check(tag, {15'd0, in_ready4}, 16'd1);
  endtask

  // Accepts a/b, checks the 4-cycle latency and the product; leaves out_ready low.
  task automatic start4(input logic [3:0] ta, input logic [3:0] tb_, input logic [7:0] exp, input string tag);
    wait_ready4({tag, "_ready"});
    a4 = ta; b4 = tb_; in_valid4 = 1'b1;
    @(negedge clk);
    in_valid4 = 1'b0; a4 = ~ta; b4 = ~tb_;
    check({tag, "_busy"}, {15'd0, busy4}, 16'd1);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      check({tag, "_early_valid"}, {15'd0, out_valid4}, 16'd0);
    end
    @(negedge clk);
    check({tag, "_valid"}, {15'd0, out_valid4}, 16'd1);
    check({tag, "_p"}, {8'h00, p4}, {8'h00, exp});
    check({tag, "_busy_done"}, {15'd0, busy4}, 16'd0);
  endtask

  task automatic handoff4(input string tag);
    out_ready4 = 1'b1;
    @(negedge clk);
    out_ready4 = 1'b0;
    check({tag, "_valid_drop"}, {15'd0, out_valid4}, 16'd0);
    check({tag, "_ready_back"}, {15'd0, in_ready4}, 16'd1);
  endtask

  initial begin
    logic [7:0]  ea, eb;
    logic [15:0] exp8;
    compared = 0; mismatched = 0;
    rst_n = 1'b0;
    in_valid4 = 1'b0; out_ready4 = 1'b0; a4 = 4'd0; b4 = 4'd0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = 8'd0; b8 = 8'd0;

    // Reset state
    @(negedge clk);
    check("rst_in_ready", {15'd0, in_ready4}, 16'd0);
    check("rst_out_valid", {15'd0, out_valid4}, 16'd0);
    check("rst_busy", {15'd0, busy4}, 16'd0);
    check("rst_p", {8'h00, p4}, 16'h0000);
    check("rst_p8", p8, 16'h0000);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_in_ready", {15'd0, in_ready4}, 16'd1);

    // Basic WIDTH=4 vectors
    start4(4'd4, 4'd1, 8'h04, "m4x1");  handoff4("m4x1");
    start4(4'd4, 4'd2, 8'h08, "m4x2");  handoff4("m4x2");
    start4(4'd5, 4'd2, 8'h0A, "m5x2");  handoff4("m5x2");
    start4(4'd2, 4'd2, 8'h04, "m2x2");  handoff4("m2x2");
`ifdef SEQ_MULT_SIGNED_EN
    start4(4'd15, 4'd15, 8'h01, "m15x15"); handoff4("m15x15");
    start4(4'hD, 4'd5, 8'hF1, "sm3x5");    handoff4("sm3x5");
    start4(4'h8, 4'h8, 8'h40, "sm8xm8");   handoff4("sm8xm8");
    start4(4'h8, 4'd7, 8'hC8, "sm8x7");    handoff4("sm8x7");
`else
    start4(4'd15, 4'd15, 8'hE1, "m15x15"); handoff4("m15x15");
`endif
    start4(4'd0, 4'd9, 8'h00, "m0x9");  handoff4("m0x9");

    // Backpressure with ignored in_valid pulses
    start4(4'd5, 4'd3, 8'h0F, "bp");
    for (int k = 0; k < 10; k++) begin
      in_valid4 = k[0]; a4 = 4'd1; b4 = 4'd1;
      @(negedge clk);
      check("bp_hold_valid", {15'd0, out_valid4}, 16'd1);
      check("bp_hold_p", {8'h00, p4}, 16'h000F);
      check("bp_hold_ready", {15'd0, in_ready4}, 16'd0);
    end
    in_valid4 = 1'b0;
    handoff4("bp");
    check("bp_p_kept", {8'h00, p4}, 16'h000F);
    start4(4'd6, 4'd3, 8'h12, "after_bp"); handoff4("after_bp");

    // Asynchronous reset two cycles into RUN
    wait_ready4("mid_ready");
    a4 = 4'd7; b4 = 4'd3; in_valid4 = 1'b1;
    @(negedge clk);
    in_valid4 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid_out_valid", {15'd0, out_valid4}, 16'd0);
    check("mid_p", {8'h00, p4}, 16'h0000);
    check("mid_busy", {15'd0, busy4}, 16'd0);
    check("mid_in_ready", {15'd0, in_ready4}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    start4(4'd3, 4'd3, 8'h09, "m3x3"); handoff4("m3x3");

    // WIDTH=8 back-to-back regression, out_ready held high
    out_ready8 = 1'b1;
    for (int i = 0; i < 50 && in_ready8 !== 1'b1; i++) @(negedge clk);
    for (int j = 0; j < 200; j++) begin
      ea = 8'($urandom_range(255, 0));
      eb = 8'($urandom_range(255, 0));
      if (j == 0) begin ea = 8'hFF; eb = 8'hFF; end
      if (j == 1) begin ea = 8'h80; eb = 8'h80; end
      exp8 = model8(ea, eb);
      check("r8_ready", {15'd0, in_ready8}, 16'd1);
      a8 = ea; b8 = eb; in_valid8 = 1'b1;
      @(negedge clk);
      in_valid8 = 1'b0; a8 = 8'($urandom_range(255, 0)); b8 = 8'($urandom_range(255, 0));
      for (int k = 1; k < 8; k++) @(negedge clk);
      check("r8_early_valid", {15'd0, out_valid8}, 16'd0);
      @(negedge clk);
      check("r8_valid", {15'd0, out_valid8}, 16'd1);
      check("r8_p", p8, exp8);
      @(negedge clk);
    end
    out_ready8 = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
